// File: rtl/periph_bus_debug_master.sv
// Byte-command debug initiator for the peripheral register bus: decodes a
// 2- or 3-byte command, arbitrates with the core via req/gnt and issues one access.
module periph_bus_debug_master #(
   parameter int unsigned TIMEOUT_CYCLES = 5000000,
   parameter logic [7:0]  ACK_BYTE       = 8'h06,
   parameter logic [7:0]  NAK_BYTE       = 8'h15
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [7:0] rx_data,
   input  logic       rx_valid,
   output logic [7:0] tx_data,
   output logic       tx_valid,
   input  logic       tx_ready,
   output logic       bus_req,
   input  logic       bus_gnt,
   output logic [8:0] dbg_addr,
   output logic       dbg_rd_en,
   output logic       dbg_wr_en,
   output logic [7:0] dbg_data_in,
   input  logic [7:0] dbg_data_out,
   output logic       busy
);

   localparam logic [2:0] ST_IDLE   = 3'd0;
   localparam logic [2:0] ST_ADDR   = 3'd1;
   localparam logic [2:0] ST_DATA   = 3'd2;
   localparam logic [2:0] ST_REQ    = 3'd3;
   localparam logic [2:0] ST_ACCESS = 3'd4;
   localparam logic [2:0] ST_RESP   = 3'd5;

   localparam bit          TO_ENABLE = (TIMEOUT_CYCLES != 0);
   localparam logic [23:0] TO_LAST   = TO_ENABLE ? 24'(TIMEOUT_CYCLES - 1) : 24'd0;

   logic [2:0]  state_reg;
   logic        is_write_reg;
   logic [8:0]  addr_reg;
   logic [7:0]  wdata_reg;
   logic [7:0]  tx_data_reg;
   logic [23:0] cnt_reg;
   logic [8:0]  dbg_addr_reg;
   logic [7:0]  dbg_data_in_reg;
   logic        expired;

   // A byte arriving on the expiry cycle takes priority over the timeout.
   assign expired = TO_ENABLE && (cnt_reg == TO_LAST) && !rx_valid;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_reg       <= ST_IDLE;
         is_write_reg    <= 1'b0;
         addr_reg        <= '0;
         wdata_reg       <= '0;
         tx_data_reg     <= '0;
         cnt_reg         <= '0;
         dbg_addr_reg    <= '0;
         dbg_data_in_reg <= '0;
      end else begin
         case (state_reg)
            ST_IDLE: begin
               if (rx_valid) begin
                  if (|rx_data[6:1]) begin
                     tx_data_reg <= NAK_BYTE;
                     state_reg   <= ST_RESP;
                  end else begin
                     is_write_reg <= rx_data[7];
                     addr_reg[8]  <= rx_data[0];
                     cnt_reg      <= '0;
                     state_reg    <= ST_ADDR;
                  end
               end
            end
            ST_ADDR: begin
               if (rx_valid) begin
                  addr_reg[7:0] <= rx_data;
                  cnt_reg       <= '0;
                  state_reg     <= is_write_reg ? ST_DATA : ST_REQ;
               end else if (expired) begin
                  state_reg <= ST_IDLE;
               end else begin
                  cnt_reg <= cnt_reg + 24'd1;
               end
            end
            ST_DATA: begin
               if (rx_valid) begin
                  wdata_reg <= rx_data;
                  cnt_reg   <= '0;
                  state_reg <= ST_REQ;
               end else if (expired) begin
                  state_reg <= ST_IDLE;
               end else begin
                  cnt_reg <= cnt_reg + 24'd1;
               end
            end
            ST_REQ: begin
               if (bus_gnt) begin
                  dbg_addr_reg    <= addr_reg;
                  dbg_data_in_reg <= wdata_reg;
                  state_reg       <= ST_ACCESS;
               end
            end
            ST_ACCESS: begin
               // Read data is captured exactly once; RCREG-style reads are destructive.
               tx_data_reg <= is_write_reg ? ACK_BYTE : dbg_data_out;
               state_reg   <= ST_RESP;
            end
            ST_RESP: begin
               if (tx_ready) state_reg <= ST_IDLE;
            end
            default: state_reg <= ST_IDLE;
         endcase
      end
   end

   // Strobes and request decode straight from state so an async reset drops them at once.
   assign dbg_rd_en   = (state_reg == ST_ACCESS) && !is_write_reg;
   assign dbg_wr_en   = (state_reg == ST_ACCESS) && is_write_reg;
   assign bus_req     = (state_reg == ST_REQ) || (state_reg == ST_ACCESS);
   assign tx_valid    = (state_reg == ST_RESP);
   assign busy        = (state_reg != ST_IDLE);
   assign tx_data     = tx_data_reg;
   assign dbg_addr    = dbg_addr_reg;
   assign dbg_data_in = dbg_data_in_reg;

endmodule

// File: tb/tb_periph_bus_debug_master.sv
// Scoreboard bench for periph_bus_debug_master: expected bus accesses and
// response bytes are queued at stimulus time and checked when the DUT emits them.
module tb_periph_bus_debug_master;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic [7:0] rx_data = '0;
   logic       rx_valid = 1'b0;
   logic [7:0] tx_data;
   logic       tx_valid;
   logic       tx_ready = 1'b1;
   logic       bus_req;
   logic       bus_gnt = 1'b1;
   logic [8:0] dbg_addr;
   logic       dbg_rd_en;
   logic       dbg_wr_en;
   logic [7:0] dbg_data_in;
   logic [7:0] dbg_data_out;
   logic       busy;

   typedef struct packed {
      logic       we;
      logic [8:0] addr;
      logic [7:0] data;
   } acc_t;

   acc_t       acc_q[$];
   logic [7:0] resp_q[$];
   logic [7:0] mem [512];
   int         n_vec = 0;
   int         n_err = 0;
   int         rd_cnt = 0;

   always #5 clk = ~clk;

   assign dbg_data_out = mem[dbg_addr];

   periph_bus_debug_master #(.TIMEOUT_CYCLES(16), .ACK_BYTE(8'h06), .NAK_BYTE(8'h15)) dut (
      .clk(clk), .rst_n(rst_n), .rx_data(rx_data), .rx_valid(rx_valid),
      .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
      .bus_req(bus_req), .bus_gnt(bus_gnt), .dbg_addr(dbg_addr),
      .dbg_rd_en(dbg_rd_en), .dbg_wr_en(dbg_wr_en), .dbg_data_in(dbg_data_in),
      .dbg_data_out(dbg_data_out), .busy(busy)
   );

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   // Monitor: every strobe and every response handshake must match the scoreboard.
   always @(negedge clk) begin
      if (rst_n) begin
         if (dbg_wr_en || dbg_rd_en) begin
            acc_t e;
            chk("strobe_onehot", 32'(dbg_wr_en & dbg_rd_en), 32'd0);
            chk("acc_expected", 32'(acc_q.size() != 0), 32'd1);
            if (dbg_rd_en) rd_cnt++;
            if (acc_q.size() != 0) begin
               e = acc_q.pop_front();
               chk("acc_we", 32'(dbg_wr_en), 32'(e.we));
               chk("acc_addr", 32'(dbg_addr), 32'(e.addr));
               if (e.we) chk("acc_wdata", 32'(dbg_data_in), 32'(e.data));
               $display("access we=%0d addr=%03h data=%02h", dbg_wr_en, dbg_addr,
                        dbg_wr_en ? dbg_data_in : dbg_data_out);
            end
         end
         if (tx_valid && tx_ready) begin
            chk("resp_expected", 32'(resp_q.size() != 0), 32'd1);
            if (resp_q.size() != 0) begin
               chk("resp_byte", 32'(tx_data), 32'(resp_q.pop_front()));
               $display("response %02h", tx_data);
            end
         end
      end
   end

   // Called at #1 after a rising edge; returns at #1 after the edge that samples the byte.
   task automatic send_byte(input logic [7:0] b);
      rx_data  = b;
      rx_valid = 1'b1;
      @(posedge clk);
      #1 rx_valid = 1'b0;
   endtask

   task automatic tick(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic wait_idle(input string tag);
      for (int i = 0; i < 100 && (busy || acc_q.size() != 0 || resp_q.size() != 0); i++) tick(1);
      chk({tag, "_drained"}, 32'(acc_q.size() + resp_q.size()), 32'd0);
      chk({tag, "_idle"}, 32'(busy), 32'd0);
   endtask

   task automatic check_reset_outputs(input string tag);
      chk({tag, "_txv"}, 32'(tx_valid), 32'd0);
      chk({tag, "_txd"}, 32'(tx_data), 32'd0);
      chk({tag, "_req"}, 32'(bus_req), 32'd0);
      chk({tag, "_strb"}, 32'({dbg_rd_en, dbg_wr_en}), 32'd0);
      chk({tag, "_addr"}, 32'(dbg_addr), 32'd0);
      chk({tag, "_din"}, 32'(dbg_data_in), 32'd0);
      chk({tag, "_busy"}, 32'(busy), 32'd0);
   endtask

   initial begin
      int rd_before;
      int bad;
      for (int i = 0; i < 512; i++) mem[i] = 8'($urandom);
      mem[9'h11A] = 8'h41;

      tick(3);
      check_reset_outputs("rst0");
      rst_n = 1'b1;
      tick(2);

      // Write with grant already present, including the minimum-latency sequence.
      acc_q.push_back('{1'b1, 9'h086, 8'h5A});
      resp_q.push_back(8'h06);
      send_byte(8'h80);
      send_byte(8'h86);
      send_byte(8'h5A);
      chk("wr_req_next", 32'(bus_req), 32'd1);
      tick(1);
      chk("wr_strobe", 32'(dbg_wr_en), 32'd1);
      tick(1);
      chk("wr_txv", 32'(tx_valid), 32'd1);
      chk("wr_req_off", 32'(bus_req), 32'd0);
      wait_idle("wr");

      // Read with the consumer stalled; data must hold and the read strobe fire once.
      tx_ready = 1'b0;
      rd_before = rd_cnt;
      acc_q.push_back('{1'b0, 9'h11A, 8'h00});
      resp_q.push_back(8'h41);
      send_byte(8'h01);
      send_byte(8'h1A);
      for (int i = 0; i < 20 && !tx_valid; i++) tick(1);
      chk("rd_txv_seen", 32'(tx_valid), 32'd1);
      bad = 0;
      for (int i = 0; i < 10; i++) begin
         if (i == 4) send_byte(8'h80);   // dropped while in RESP
         else tick(1);
         if (tx_data !== 8'h41 || !tx_valid) bad++;
      end
      chk("rd_hold", 32'(bad), 32'd0);
      chk("rd_once", 32'(rd_cnt - rd_before), 32'd1);
      tx_ready = 1'b1;
      wait_idle("rd");

      // Grant withheld for 20 cycles after the command.
      bus_gnt = 1'b0;
      acc_q.push_back('{1'b1, 9'h123, 8'hC3});
      resp_q.push_back(8'h06);
      send_byte(8'h81);
      send_byte(8'h23);
      send_byte(8'hC3);
      bad = 0;
      for (int i = 0; i < 20; i++) begin
         if (!bus_req || dbg_wr_en || dbg_rd_en) bad++;
         tick(1);
      end
      chk("gnt_wait", 32'(bad), 32'd0);
      bus_gnt = 1'b1;
      tick(1);
      chk("gnt_access", 32'(dbg_wr_en), 32'd1);
      wait_idle("gnt");

      // Malformed byte 0 then a normal read.
      resp_q.push_back(8'h15);
      send_byte(8'h42);
      chk("nak_no_req", 32'(bus_req), 32'd0);
      wait_idle("nak");
      acc_q.push_back('{1'b0, 9'h055, 8'h00});
      resp_q.push_back(mem[9'h055]);
      send_byte(8'h00);
      send_byte(8'h55);
      wait_idle("rd2");

      // Byte timeout: silence after byte 0 returns to IDLE after 16 cycles.
      send_byte(8'h80);
      tick(15);
      chk("to_busy15", 32'(busy), 32'd1);
      tick(1);
      chk("to_idle16", 32'(busy), 32'd0);
      tick(3);
      chk("to_noresp", 32'(tx_valid), 32'd0);

      // A byte on the expiry cycle wins.
      acc_q.push_back('{1'b1, 9'h0F0, 8'h3C});
      resp_q.push_back(8'h06);
      send_byte(8'h80);
      tick(15);
      send_byte(8'hF0);
      chk("to_edge_busy", 32'(busy), 32'd1);
      send_byte(8'h3C);
      wait_idle("to_edge");

      // Asynchronous reset during ACCESS of a write.
      bus_gnt = 1'b0;
      send_byte(8'h80);
      send_byte(8'h10);
      send_byte(8'h77);
      bus_gnt = 1'b1;
      @(posedge clk);
      #1 chk("rst_pre_strobe", 32'(dbg_wr_en), 32'd1);
      #1 rst_n = 1'b0;
      #1 chk("rst_async_wr", 32'(dbg_wr_en), 32'd0);
      chk("rst_async_req", 32'(bus_req), 32'd0);
      tick(2);
      rst_n = 1'b1;
      tick(2);
      check_reset_outputs("rst1");

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
